// File: rtl/pci_arb_pkg.sv
// ---------------------------------------------------------------------------
// pci_arb_pkg
// Shared definitions for the four-device PCI round-robin arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, GRANT, BUSY)
//   - DEV_A..DEV_D: device index constants (A=0 .. D=3)
//   - DEFAULT_TIMEOUT: default idle-bus clocks before a grant is revoked
// ---------------------------------------------------------------------------
package pci_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    BUSY  = 2'd2
  } arb_state_t;

  localparam logic [1:0] DEV_A = 2'd0;
  localparam logic [1:0] DEV_B = 2'd1;
  localparam logic [1:0] DEV_C = 2'd2;
  localparam logic [1:0] DEV_D = 2'd3;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/pci_rr_pick.sv
// ---------------------------------------------------------------------------
// pci_rr_pick
// Combinational 4-way rotating-priority picker. The device just after
// 'last' has the highest priority, 'last' itself the lowest.
// Ports:
//   req    in  [3:0] active-high request vector (bit n = device n)
//   last   in  [1:0] most recent device to own the bus or time out
//   winner out [1:0] selected device (meaningless when any = 0)
//   any    out       at least one request present
// ---------------------------------------------------------------------------
module pci_rr_pick (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] winner,
  output logic       any
);

  // Walk from the lowest-priority offset to the highest so that the
  // final assignment made is the closest requester after 'last'.
  always_comb begin
    winner = last;
    any    = |req;
    for (int i = 3; i >= 0; i--) begin
      if (req[last + 2'(i + 1)]) begin
        winner = last + 2'(i + 1);
      end
    end
  end

endmodule

// File: rtl/pci_rr_arbiter.sv
// ---------------------------------------------------------------------------
// pci_rr_arbiter
// Central PCI arbiter for devices A-D with round-robin priority, hidden
// re-arbitration while a transaction is in flight, and a watchdog that
// revokes a grant from a master that never starts its transaction.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   REQ_A..REQ_D          bus requests, active low
//   Frame, IRDY           shared FRAME# / IRDY#, active low
//   GNT_A..GNT_D          registered grants, active low, at most one low
//   grant_id      [1:0]   device currently granted (valid with grant_valid)
//   grant_valid           high while any GNT is low
//   timeout_evt           one-cycle pulse when the watchdog revokes a grant
// ---------------------------------------------------------------------------
module pci_rr_arbiter
  import pci_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       REQ_A,
  input  logic       REQ_B,
  input  logic       REQ_C,
  input  logic       REQ_D,
  input  logic       Frame,
  input  logic       IRDY,
  output logic       GNT_A,
  output logic       GNT_B,
  output logic       GNT_C,
  output logic       GNT_D,
  output logic [1:0] grant_id,
  output logic       grant_valid,
  output logic       timeout_evt
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = {TW{1'b1}};

  arb_state_t    state;
  logic [1:0]    cur;
  logic [1:0]    last;
  logic [TW-1:0] timer;
  logic [3:0]    gnt_n;

  logic [3:0]    req_act;
  logic [3:0]    pick_req;
  logic [1:0]    pick_win;
  logic          pick_any;
  logic          bus_idle;

  assign req_act  = ~{REQ_D, REQ_C, REQ_B, REQ_A};
  assign bus_idle = Frame & IRDY;

  // While a transaction is in flight only the other devices compete for
  // the hidden re-grant; the current owner is masked out.
  assign pick_req = (state == BUSY) ? (req_act & ~(4'b0001 << cur)) : req_act;

  pci_rr_pick u_pick (
    .req    (pick_req),
    .last   (last),
    .winner (pick_win),
    .any    (pick_any)
  );

  // Arbiter FSM. Grants are registered, so a request sampled at an edge
  // produces its GNT right after that edge. Leaving GRANT/BUSY for IDLE
  // gives the one all-high turnaround clock before the next grant, while
  // a hidden re-grant from BUSY swaps GNT lines on a single edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cur         <= DEV_A;
      last        <= DEV_D;
      timer       <= '0;
      gnt_n       <= 4'hF;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            cur   <= pick_win;
            gnt_n <= ~(4'b0001 << pick_win);
            timer <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!Frame) begin
            last  <= cur;
            timer <= '0;
            state <= BUSY;
          end else if (!req_act[cur]) begin
            gnt_n <= 4'hF;
            state <= IDLE;
          end else if (bus_idle && timer == T_LAST) begin
            gnt_n       <= 4'hF;
            timeout_evt <= 1'b1;
            last        <= cur;
            state       <= IDLE;
          end else if (bus_idle && timer != T_MAX) begin
            timer <= timer + TW'(1);
          end
        end
        BUSY: begin
          if (pick_any) begin
            cur   <= pick_win;
            gnt_n <= ~(4'b0001 << pick_win);
            timer <= '0;
            state <= GRANT;
          end else if (bus_idle && !req_act[cur]) begin
            gnt_n <= 4'hF;
            state <= IDLE;
          end
        end
        default: begin
          gnt_n <= 4'hF;
          state <= IDLE;
        end
      endcase
    end
  end

  assign GNT_A       = gnt_n[0];
  assign GNT_B       = gnt_n[1];
  assign GNT_C       = gnt_n[2];
  assign GNT_D       = gnt_n[3];
  assign grant_id    = cur;
  assign grant_valid = ~&gnt_n;

endmodule

// File: tb/tb_pci_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_pci_rr_arbiter
// Self-checking bench for pci_rr_arbiter: directed scenarios followed by
// randomized traffic, all compared cycle by cycle against a behavioural
// model of the arbitration rules.
// ---------------------------------------------------------------------------
module tb_pci_rr_arbiter;

  localparam int TIMEOUT = 16;

  logic       clk;
  logic       rst;
  logic       REQ_A, REQ_B, REQ_C, REQ_D;
  logic       Frame, IRDY;
  logic       GNT_A, GNT_B, GNT_C, GNT_D;
  logic [1:0] grant_id;
  logic       grant_valid;
  logic       timeout_evt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: who holds the grant, whether that device has
  // started using the bus, how long it has waited on an idle bus, and the
  // rotation base for the next pick.
  int m_phase;   // 0 = no grant, 1 = granted and waiting, 2 = owns bus
  int m_cur;
  int m_last;
  int m_wait;
  bit m_tevt;

  pci_rr_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .REQ_A       (REQ_A),
    .REQ_B       (REQ_B),
    .REQ_C       (REQ_C),
    .REQ_D       (REQ_D),
    .Frame       (Frame),
    .IRDY        (IRDY),
    .GNT_A       (GNT_A),
    .GNT_B       (GNT_B),
    .GNT_C       (GNT_C),
    .GNT_D       (GNT_D),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout_evt (timeout_evt)
  );

  // Free-running bus clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // First requester strictly after 'base' in circular order, or -1.
  function automatic int next_after(input bit [3:0] req, input int base);
    for (int k = 1; k <= 4; k++) begin
      if (req[(base + k) % 4]) return (base + k) % 4;
    end
    return -1;
  endfunction

  // Counts one comparison and reports it when it does not hold.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Advances the model by one clock with the inputs the DUT will sample.
  task automatic modelStep(input bit r, input bit [3:0] req, input bit fl, input bit il);
    bit       idle;
    bit [3:0] others;
    int       w;
    idle   = !fl && !il;
    m_tevt = 1'b0;
    if (r) begin
      m_phase = 0;
      m_cur   = 0;
      m_last  = 3;
      m_wait  = 0;
    end else if (m_phase == 0) begin
      w = next_after(req, m_last);
      if (w >= 0) begin
        m_cur   = w;
        m_phase = 1;
        m_wait  = 0;
      end
    end else if (m_phase == 1) begin
      if (fl) begin
        m_last  = m_cur;
        m_phase = 2;
      end else if (!req[m_cur]) begin
        m_phase = 0;
      end else if (idle && m_wait + 1 == TIMEOUT) begin
        m_phase = 0;
        m_tevt  = 1'b1;
        m_last  = m_cur;
      end else if (idle) begin
        m_wait++;
      end
    end else begin
      others = req;
      others[m_cur] = 1'b0;
      w = next_after(others, m_cur);
      if (w >= 0) begin
        m_cur   = w;
        m_phase = 1;
        m_wait  = 0;
      end else if (idle && !req[m_cur]) begin
        m_phase = 0;
      end
    end
  endtask

  // Drives one clock of inputs (req/fl/il active-high), steps the model,
  // then samples and compares the DUT just after the rising edge.
  task automatic applyStimulus(input bit r, input bit [3:0] req, input bit fl, input bit il);
    bit [3:0] exp_gnt;
    @(negedge clk);
    rst   = r;
    REQ_A = ~req[0];
    REQ_B = ~req[1];
    REQ_C = ~req[2];
    REQ_D = ~req[3];
    Frame = ~fl;
    IRDY  = ~il;
    modelStep(r, req, fl, il);
    @(posedge clk);
    #1;
    exp_gnt = 4'hF;
    if (m_phase != 0) exp_gnt[m_cur] = 1'b0;
    checkOutput("gnt", {GNT_D, GNT_C, GNT_B, GNT_A}, exp_gnt);
    checkOutput("grant_valid", grant_valid, (m_phase != 0));
    checkOutput("timeout_evt", timeout_evt, m_tevt);
    if (m_phase != 0) checkOutput("grant_id", grant_id, m_cur);
  endtask

  initial begin
    bit [3:0] rq;
    bit       fl;
    bit       il;
    bit       r;
    rst = 1'b1; REQ_A = 1'b1; REQ_B = 1'b1; REQ_C = 1'b1; REQ_D = 1'b1;
    Frame = 1'b1; IRDY = 1'b1;
    m_phase = 0; m_cur = 0; m_last = 3; m_wait = 0; m_tevt = 1'b0;

    // Reset held with REQ_A asserted, then released: A is granted first.
    for (int i = 0; i < 3; i++) applyStimulus(1, 4'b0001, 0, 0);
    checkOutput("reset_grant_id", grant_id, 2'd0);
    applyStimulus(0, 4'b0001, 0, 0);
    checkOutput("first_grant_A", GNT_A, 1'b0);
    applyStimulus(0, 4'b0000, 0, 0);

    // Fairness: everyone requests, each granted master pulses Frame once.
    for (int i = 0; i < 14; i++) applyStimulus(0, 4'hF, (m_phase == 1), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 4'h0, 0, 0);

    // Watchdog: only B requests on an idle bus.
    applyStimulus(1, 4'h0, 0, 0);
    for (int i = 0; i < 2 * TIMEOUT + 6; i++) applyStimulus(0, 4'b0010, 0, 0);
    applyStimulus(0, 4'h0, 0, 0);

    // Hidden arbitration: A holds Frame for 5 clocks, C requests from clock 2.
    applyStimulus(1, 4'h0, 0, 0);
    applyStimulus(0, 4'b0001, 0, 0);
    applyStimulus(0, 4'b0001, 1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'b0101, 1, 1);
    for (int i = 0; i < 4; i++) applyStimulus(0, 4'b0100, 0, 0);
    applyStimulus(0, 4'h0, 0, 0);
    applyStimulus(0, 4'h0, 0, 0);

    // Withdrawal: D granted, then drops REQ before starting.
    applyStimulus(0, 4'b1000, 0, 0);
    applyStimulus(0, 4'b1000, 0, 0);
    applyStimulus(0, 4'b0000, 0, 0);
    applyStimulus(0, 4'hF, 0, 0);
    applyStimulus(0, 4'h0, 0, 0);

    // Reset in the middle of B's transaction, then all request.
    applyStimulus(1, 4'h0, 0, 0);
    applyStimulus(0, 4'b0010, 0, 0);
    applyStimulus(0, 4'b0010, 1, 1);
    applyStimulus(0, 4'b0010, 1, 1);
    applyStimulus(1, 4'b0010, 1, 1);
    applyStimulus(0, 4'hF, 0, 0);
    checkOutput("post_reset_A", grant_id, 2'd0);

    // Randomized traffic with sticky requests and occasional resets.
    rq = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(7) == 0) rq[b] = ~rq[b];
      end
      fl = ($urandom_range(9) < 3);
      il = fl ? ($urandom_range(1) == 1) : ($urandom_range(9) == 0);
      if (i % 500 > 400) begin
        fl = 1'b0;
        il = 1'b0;
      end
      r = ($urandom_range(199) == 0);
      applyStimulus(r, rq, fl, il);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
